ps2_key_decoder: RTL

- Second-generation PS/2 scan-code decoder. Consumes bytes from the PS/2 receiver and tracks make/break, E0-extended codes and modifier state (shift, ctrl, alt, caps lock).
- Filters typematic repeats and maps codes to shift/caps-aware ASCII.
- Buffers decoded key presses in a parametrised ready/valid FIFO for the CPU/UART side. Also drives last-key outputs for the seven-segment display.

---
 rtl/ps2_pkg.sv | 64 ++++++
 rtl/ps2_key_fifo.sv | 45 ++++
 rtl/ps2_key_decoder.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, prefix-FSM state, FIFO entry layout and the
// scan-code to ASCII lookup used by the PS/2 key decoder.
package ps2_pkg;

  localparam logic [7:0] SC_E0     = 8'hE0;
  localparam logic [7:0] SC_F0     = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
    logic [7:0] ascii;
    logic [2:0] mods;
  } ps2_entry_t;

  localparam int ENTRY_W = $bits(ps2_entry_t);

  // Letters fold to uppercase when shift XOR caps; digits use the shifted
  // symbol row only with shift (caps lock does not affect them).
  function automatic logic [7:0] ps2_to_ascii(input logic [7:0] code, input logic ext,
                                              input logic shift, input logic caps);
    logic [7:0] a;
    a = 8'h00;
    if (!ext) begin
      case (code)
        8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
        8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
        8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
        8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
        8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
        8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
        8'h35: a = "y";  8'h1A: a = "z";
        8'h16: a = shift ? "!" : "1";
        8'h1E: a = shift ? "@" : "2";
        8'h26: a = shift ? "#" : "3";
        8'h25: a = shift ? "$" : "4";
        8'h2E: a = shift ? "%" : "5";
        8'h36: a = shift ? "^" : "6";
        8'h3D: a = shift ? "&" : "7";
        8'h3E: a = shift ? "*" : "8";
        8'h46: a = shift ? "(" : "9";
        8'h45: a = shift ? ")" : "0";
        8'h29: a = 8'h20;
        8'h5A: a = 8'h0D;
        8'h66: a = 8'h08;
        default: a = 8'h00;
      endcase
      if (a >= "a" && a <= "z" && (shift ^ caps)) a = a - 8'h20;
    end
    return a;
  endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// Synchronous ready/valid FIFO with wrap-bit pointers and a sticky overflow
// flag raised whenever a push has to be dropped.
module ps2_key_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full, pop, push_ok;

  assign out_valid = (wr_ptr != rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = out_valid && pop_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok   = push && (!full || pop);
  assign out_data  = out_valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: prefix FSM, modifier tracking, typematic filter,
// ASCII mapping and a key-event FIFO plus last-key display outputs.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_FILTER = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_code,
  output logic             out_ext,
  output logic [7:0]       out_ascii,
  output logic [2:0]       out_mods,
  output logic             overflow,
  output logic [7:0]       last_code,
  output logic [7:0]       last_ascii,
  output logic             key_held,
  output logic             shift_held,
  output logic             ctrl_held,
  output logic             alt_held,
  output logic             caps_lock,
  output logic [CNT_W-1:0] press_cnt
);
  ps2_state_t   state;
  logic         c_ext, c_brk, done;
  logic         m_lshift, m_rshift, m_ctrl, m_alt, m_fake, m_caps, is_mod;
  logic         lshift, rshift, caps_down;
  logic [8:0]   held_key;
  logic         same_key, make_ev, brk_match;
  logic [7:0]   cur_ascii;
  ps2_entry_t   push_entry, head;
  logic [ENTRY_W-1:0] head_bits;

  assign c_ext = (state == ST_EXT) || (state == ST_EXT_BRK);
  assign c_brk = (state == ST_BRK) || (state == ST_EXT_BRK);
  assign done  = rx_valid && (rx_data != SC_E0) && (rx_data != SC_F0);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else if (rx_valid) begin
      if (rx_data == SC_E0) state <= ST_EXT;
      else if (rx_data == SC_F0) state <= c_ext ? ST_EXT_BRK : ST_BRK;
      else state <= ST_IDLE;
    end
  end

  // E0 12 / E0 59 are the fake shifts some keyboards wrap around E0 keys.
  assign m_lshift = !c_ext && (rx_data == SC_LSHIFT);
  assign m_rshift = !c_ext && (rx_data == SC_RSHIFT);
  assign m_ctrl   = (rx_data == SC_CTRL);
  assign m_alt    = (rx_data == SC_ALT);
  assign m_fake   = c_ext && ((rx_data == SC_LSHIFT) || (rx_data == SC_RSHIFT));
  assign m_caps   = !c_ext && (rx_data == SC_CAPS);
  assign is_mod   = m_lshift | m_rshift | m_ctrl | m_alt | m_fake | m_caps;

  assign shift_held = lshift | rshift;
  assign same_key   = key_held && (held_key == {c_ext, rx_data});
  assign make_ev    = done && !c_brk && !is_mod && !((REPEAT_FILTER != 0) && same_key);
  assign brk_match  = done && c_brk && !is_mod && same_key;
  assign cur_ascii  = ps2_to_ascii(rx_data, c_ext, shift_held, caps_lock);

  always_comb begin
    push_entry       = '0;
    push_entry.ext   = c_ext;
    push_entry.code  = rx_data;
    push_entry.ascii = cur_ascii;
    push_entry.mods  = {alt_held, ctrl_held, shift_held};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lshift    <= 1'b0;
      rshift    <= 1'b0;
      ctrl_held <= 1'b0;
      alt_held  <= 1'b0;
      caps_lock <= 1'b0;
      caps_down <= 1'b0;
    end else if (done) begin
      if (m_lshift) lshift <= !c_brk;
      if (m_rshift) rshift <= !c_brk;
      if (m_ctrl) ctrl_held <= !c_brk;
      if (m_alt) alt_held <= !c_brk;
      if (m_caps) begin
        if (!c_brk && !caps_down) caps_lock <= ~caps_lock;
        caps_down <= !c_brk;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_held   <= 1'b0;
      held_key   <= '0;
      press_cnt  <= '0;
      last_code  <= '0;
      last_ascii <= '0;
    end else if (make_ev) begin
      key_held   <= 1'b1;
      held_key   <= {c_ext, rx_data};
      press_cnt  <= press_cnt + CNT_W'(1);
      last_code  <= rx_data;
      last_ascii <= cur_ascii;
    end else if (brk_match) begin
      key_held <= 1'b0;
    end
  end

  ps2_key_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (make_ev),
    .push_data (push_entry),
    .pop_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (head_bits),
    .overflow  (overflow)
  );

  assign head      = head_bits;
  assign out_ext   = head.ext;
  assign out_code  = head.code;
  assign out_ascii = head.ascii;
  assign out_mods  = head.mods;

endmodule
